// File: rtl/x_edge_finder_if.sv
// Snapshot-in / edge-result-out handshake bundle for x_edge_finder.
// slave is the finder's view, master is the producer/consumer side.
interface x_edge_finder_if #(
  parameter int P_WIDTH = 256
);
  localparam int PW = $clog2(P_WIDTH);

  logic               i_valid;
  logic               o_ready;
  logic [P_WIDTH-1:0] i_data;
  logic               o_valid;
  logic               i_ready;
  logic [PW-1:0]      o_pos;
  logic               o_found;
  logic               o_rising;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_pos, o_found, o_rising
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_pos, o_found, o_rising
  );
endinterface

// File: rtl/x_edge_finder.sv
// First-transition finder for a delay-line thermometer snapshot, scanned P_SLICE bits per cycle.
// Optional position averaging over 2^P_AVG_LOG2 captures is compiled in with X_EDGE_FINDER_AVG_EN.
//
// state | meaning
// IDLE  | ready for a snapshot, o_ready=1
// SCAN  | walking slices 0..P_WIDTH/P_SLICE-1, one per cycle, fixed length
// OUT   | result held on o_valid until i_ready
module x_edge_finder #(
  parameter int P_WIDTH    = 256,
  parameter int P_SLICE    = 16,
  parameter int P_AVG_LOG2 = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  x_edge_finder_if.slave bus
);
  localparam int PW  = $clog2(P_WIDTH);
  localparam int SW  = $clog2(P_SLICE);
  localparam int NSL = P_WIDTH / P_SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  generate
    if (P_SLICE < 2 || (P_WIDTH % P_SLICE) != 0 || NSL < 2 || P_AVG_LOG2 < 1) begin : g_bad_param
      $error("x_edge_finder: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [P_WIDTH-1:0] data_q;
  logic [CW-1:0]      slice_cnt;
  logic               carry_q;
  logic               hit_q;
  logic [PW-1:0]      hit_pos_q;
  logic               hit_rise_q;

  logic [P_SLICE-1:0] slice;
  logic [P_SLICE-1:0] diff;
  logic               slice_hit;
  logic [SW-1:0]      slice_idx;
  logic               slice_rise;
  logic               last_slice;
  logic               hit_now;
  logic [PW-1:0]      pos_now;
  logic               rise_now;

`ifdef X_EDGE_FINDER_AVG_EN
  localparam int AW = PW + P_AVG_LOG2;
  logic [AW-1:0]         acc_q;
  logic [P_AVG_LOG2-1:0] cap_q;
  logic [AW-1:0]         sum;
  logic                  cap_last;
`endif

  // Data register shifts down one slice per cycle, so the live slice is always the LSBs.
  always_comb begin
    slice      = data_q[P_SLICE-1:0];
    diff       = slice ^ {slice[P_SLICE-2:0], carry_q};
    if (slice_cnt == '0) diff[0] = 1'b0;
    slice_hit  = 1'b0;
    slice_idx  = '0;
    slice_rise = 1'b0;
    for (int i = P_SLICE - 1; i >= 0; i--) begin
      if (diff[i]) begin
        slice_hit  = 1'b1;
        slice_idx  = i[SW-1:0];
        slice_rise = slice[i];
      end
    end
  end

  always_comb begin
    last_slice = (slice_cnt == CW'(NSL - 1));
    hit_now    = hit_q | slice_hit;
    pos_now    = '0;
    rise_now   = 1'b0;
    if (hit_q) begin
      pos_now  = hit_pos_q;
      rise_now = hit_rise_q;
    end else if (slice_hit) begin
      pos_now  = {slice_cnt, slice_idx};
      rise_now = slice_rise;
    end
  end

`ifdef X_EDGE_FINDER_AVG_EN
  always_comb begin
    sum      = acc_q + AW'(pos_now);
    cap_last = (cap_q == '1);
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.i_valid) state_nx = SCAN;
      SCAN: begin
        if (last_slice) begin
`ifdef X_EDGE_FINDER_AVG_EN
          state_nx = (hit_now && !cap_last) ? IDLE : OUT;
`else
          state_nx = OUT;
`endif
        end
      end
      OUT:  if (bus.i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == OUT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q       <= '0;
      slice_cnt    <= '0;
      carry_q      <= 1'b0;
      hit_q        <= 1'b0;
      hit_pos_q    <= '0;
      hit_rise_q   <= 1'b0;
      bus.o_pos    <= '0;
      bus.o_found  <= 1'b0;
      bus.o_rising <= 1'b0;
`ifdef X_EDGE_FINDER_AVG_EN
      acc_q        <= '0;
      cap_q        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            data_q     <= bus.i_data;
            slice_cnt  <= '0;
            carry_q    <= 1'b0;
            hit_q      <= 1'b0;
            hit_pos_q  <= '0;
            hit_rise_q <= 1'b0;
          end
        end
        SCAN: begin
          data_q     <= data_q >> P_SLICE;
          carry_q    <= slice[P_SLICE-1];
          slice_cnt  <= slice_cnt + CW'(1);
          hit_q      <= hit_now;
          hit_pos_q  <= pos_now;
          hit_rise_q <= rise_now;
          if (last_slice) begin
`ifdef X_EDGE_FINDER_AVG_EN
            if (!hit_now) begin
              bus.o_pos    <= '0;
              bus.o_found  <= 1'b0;
              bus.o_rising <= 1'b0;
              acc_q        <= '0;
              cap_q        <= '0;
            end else if (!cap_last) begin
              acc_q <= sum;
              cap_q <= cap_q + 1'b1;
            end else begin
              // Truncating mean: drop the low P_AVG_LOG2 bits of the sum.
              bus.o_pos    <= sum[AW-1:P_AVG_LOG2];
              bus.o_found  <= 1'b1;
              bus.o_rising <= rise_now;
              acc_q        <= '0;
              cap_q        <= '0;
            end
`else
            bus.o_pos    <= pos_now;
            bus.o_found  <= hit_now;
            bus.o_rising <= rise_now;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/x_edge_finder.md
# x_edge_finder

Downstream consumer of the 256-bit delay-line snapshot. It accepts one captured thermometer word per handshake and scans it in fixed-width slices. It reports the bit index of the first transition, its polarity and a found flag on a valid/ready output. The result feeds the calibration/readout path in place of shipping the raw 256-bit word.

## Interface
- P_WIDTH, 256, snapshot width; power of two, multiple of P_SLICE
- P_SLICE, 16, bits examined per scan cycle
- P_AVG_LOG2, 2, log2 of captures averaged (only with averaging compiled in)
- i_clk  input  1  single clock
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  snapshot present on i_data
- o_ready  output  1  block can accept a snapshot
- i_data  input  P_WIDTH  delay-line snapshot
- o_valid  output  1  result present
- i_ready  input  1  consumer takes result
- o_pos  output  log2(P_WIDTH)  index of first transition
- o_found  output  1  a transition exists in the snapshot
- o_rising  output  1  value of snapshot bit at o_pos (1 = 0→1)

## Operation
- Edge definition: lowest k in 1..P_WIDTH-1 with data[k] != data[k-1]. No such k gives o_found=0, o_pos=0, o_rising=0.
- FSM states:
  - IDLE: o_ready=1. On i_valid, register i_data and go to SCAN with slice counter = 0.
  - SCAN: examine slice j (bits j*P_SLICE .. j*P_SLICE+P_SLICE-1) each cycle. The compare at bit j*P_SLICE uses the last bit of slice j-1, carried in a register. Bit 0 is never an edge. Record the first edge only; later edges are ignored.
  - SCAN always runs all P_WIDTH/P_SLICE cycles; there is no early exit.
  - After the last slice, go to OUT (or back to IDLE, see Configuration).
  - OUT: o_valid=1 with outputs registered and stable. On i_ready, go to IDLE.
- o_ready=1 only in IDLE. i_valid in any other state is ignored and no data is captured.
- Reset, asynchronous and at any point including mid-SCAN or in OUT:
  - state = IDLE
  - o_valid=0, o_pos=0, o_found=0, o_rising=0, o_ready=1
  - accumulator = 0, capture counter = 0
  - any partial scan or partial average is discarded.

## Timing
- Accept handshake in cycle N (i_valid & o_ready).
- SCAN occupies cycles N+1 .. N+P_WIDTH/P_SLICE.
- o_valid rises in cycle N+1+P_WIDTH/P_SLICE; with defaults that is N+17.
- o_valid holds until the cycle with i_ready=1. o_ready returns 1 the following cycle.
- Maximum throughput: one result per P_WIDTH/P_SLICE+2 cycles.
- i_ready asserted while o_valid=0 has no effect.

## Configuration
- Macro: X_EDGE_FINDER_AVG_EN.
- Defined:
  - A found edge with capture count < 2^P_AVG_LOG2-1 adds o_pos into an accumulator of width log2(P_WIDTH)+P_AVG_LOG2, increments the count and returns to IDLE without asserting o_valid.
  - On the final capture, o_pos = (acc + pos) >> P_AVG_LOG2, truncated. o_found=1, o_rising = polarity of the final capture. The block then enters OUT, and acc and count clear.
  - A not-found capture clears acc and count and enters OUT immediately with o_found=0.
- Undefined: every capture produces a result; no accumulator exists; P_AVG_LOG2 is unused.

## Test plan
- i_data=256'hFF (bits 0–7 high), accepted at cycle N -> o_valid at N+17, o_pos=8, o_found=1, o_rising=0.
- i_data=0, then i_data=all ones -> both give o_found=0, o_pos=0, o_rising=0.
- Slice-boundary edge: bits 0–15 low, bits 16–255 high -> o_pos=16, o_rising=1. Bits 0–14 low, 15–255 high -> o_pos=15.
- Multiple edges: i_data=256'hF0F0 -> o_pos=4, o_rising=1.
- Backpressure: hold i_ready=0 for 10 cycles in OUT while toggling i_valid and i_data -> outputs stable, o_ready=0, no capture. Raise i_ready -> o_valid drops next cycle and o_ready=1.
- X_EDGE_FINDER_AVG_EN on, P_AVG_LOG2=2:
  - Edges 8, 9, 10, 12 -> single result o_pos=9 (39>>2) after the fourth scan.
  - Assert i_rst mid-SCAN of the third capture -> all outputs at reset values. A fresh run of four edges at 20 -> o_pos=20.
